jbi_iob_rptr_skid: RTL and testbench

JBI_IOB_RPTR_SKID -- requirements
Module: jbi_iob_rptr_skid

---
 rtl/jbi_iob_rptr_skid_pkg.sv | 12 +
 rtl/rptr_dffre.sv | 20 ++
 rtl/jbi_iob_rptr_skid.sv | 95 +++++++++
 tb/tb_jbi_iob_rptr_skid.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/jbi_iob_rptr_skid_pkg.sv
// Shared types and constants for the JBI-to-IOB repeater skid buffer.
package jbi_iob_rptr_skid_pkg;

  localparam int unsigned JBI_IOB_RPTR_WIDTH = 136;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

endpackage

// File: rtl/rptr_dffre.sv
// Width-wide flop with synchronous active-high reset and load enable.
module rptr_dffre #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/jbi_iob_rptr_skid.sv
// Two-entry repeater between JBI and IOB: main entry drives sig_buf, skid absorbs
// the beat that arrives while the registered stall_out is still low.
module jbi_iob_rptr_skid
  import jbi_iob_rptr_skid_pkg::*;
#(
  parameter int unsigned WIDTH = JBI_IOB_RPTR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_vld,
  input  logic [WIDTH-1:0] sig,
  output logic             stall_out,
  output logic             sig_buf_vld,
  output logic [WIDTH-1:0] sig_buf,
  input  logic             stall_in
);

  state_e           state_q, state_d;
  logic             stall_q, vld_q;
  logic             accept, consume;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign accept      = sig_vld & ~stall_q;
  assign consume     = vld_q & ~stall_in;
  assign stall_out   = stall_q;
  assign sig_buf_vld = vld_q;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = sig;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_en = 1'b1;
        end
      end
      StOne: begin
        if (accept && consume) begin
          main_en = 1'b1;
        end else if (accept) begin
          state_d = StTwo;
          skid_en = 1'b1;
        end else if (consume) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (consume) begin
          state_d = StOne;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Stall and valid are flopped from the next state so stall_in never reaches stall_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      stall_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= (state_d == StTwo);
      vld_q   <= (state_d != StEmpty);
    end
  end

  rptr_dffre #(
    .Width(WIDTH)
  ) u_main (
    .clk(clk),
    .rst(rst),
    .en (main_en),
    .d  (main_d),
    .q  (sig_buf)
  );

  rptr_dffre #(
    .Width(WIDTH)
  ) u_skid (
    .clk(clk),
    .rst(rst),
    .en (skid_en),
    .d  (sig),
    .q  (skid_q)
  );

endmodule

// File: tb/tb_jbi_iob_rptr_skid.sv
// Directed and randomized checks of the JBI-to-IOB repeater skid buffer.
module tb_jbi_iob_rptr_skid;

  localparam int unsigned W = 136;

  logic         clk;
  logic         rst;
  logic         sig_vld;
  logic [W-1:0] sig;
  logic         stall_out;
  logic         sig_buf_vld;
  logic [W-1:0] sig_buf;
  logic         stall_in;

  int unsigned passed = 0;
  int unsigned total  = 0;

  jbi_iob_rptr_skid #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_vld    (sig_vld),
    .sig        (sig),
    .stall_out  (stall_out),
    .sig_buf_vld(sig_buf_vld),
    .sig_buf    (sig_buf),
    .stall_in   (stall_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [W-1:0] d, input logic s);
    sig_vld  = v;
    sig      = d;
    stall_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Status of sig_buf_vld, stall_out and (when valid) sig_buf in one call.
  task automatic chk3(input string tag, input logic v, input logic s, input logic [W-1:0] d);
    chkb({tag, "_vld"}, sig_buf_vld, v);
    chkb({tag, "_stall"}, stall_out, s);
    chk({tag, "_data"}, sig_buf, d);
  endtask

  logic [W-1:0] q[$];
  int unsigned  cnt;
  logic         hold;
  logic         acc;
  logic         con;

  initial begin
    rst      = 1'b1;
    sig_vld  = 1'b0;
    sig      = '0;
    stall_in = 1'b0;

    // Reset with sig_vld high: the beat must not be taken.
    cyc(1'b1, W'(136'hff), 1'b0);
    cyc(1'b1, W'(136'hff), 1'b0);
    chk3("reset", 1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk3("post_reset", 1'b0, 1'b0, '0);

    // Single beat, one-cycle latency.
    cyc(1'b1, W'(1), 1'b0);
    chk3("single", 1'b1, 1'b0, W'(1));
    cyc(1'b0, '0, 1'b0);
    chkb("single_done_vld", sig_buf_vld, 1'b0);

    // Back-to-back stream 1..8.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      chk3($sformatf("stream%0d", i), 1'b1, 1'b0, W'(i));
    end
    cyc(1'b0, '0, 1'b0);
    chkb("stream_done_vld", sig_buf_vld, 1'b0);

    // A, B with IOB stalled; C must wait on sig until the skid drains.
    cyc(1'b1, W'(136'ha), 1'b1);
    chk3("stall_a", 1'b1, 1'b0, W'(136'ha));
    cyc(1'b1, W'(136'hb), 1'b1);
    chk3("stall_two", 1'b1, 1'b1, W'(136'ha));
    cyc(1'b1, W'(136'hc), 1'b1);
    chk3("stall_hold1", 1'b1, 1'b1, W'(136'ha));
    cyc(1'b1, W'(136'hc), 1'b1);
    chk3("stall_hold2", 1'b1, 1'b1, W'(136'ha));
    cyc(1'b1, W'(136'hc), 1'b0);
    chk3("drain_b", 1'b1, 1'b0, W'(136'hb));
    cyc(1'b1, W'(136'hc), 1'b0);
    chk3("drain_c", 1'b1, 1'b0, W'(136'hc));
    cyc(1'b0, '0, 1'b0);
    chkb("drain_empty_vld", sig_buf_vld, 1'b0);

    // Accept/consume overlap with alternating stall_in.
    cyc(1'b1, W'(136'h11), 1'b0);
    chk3("alt11", 1'b1, 1'b0, W'(136'h11));
    cyc(1'b1, W'(136'h12), 1'b0);
    chk3("alt12", 1'b1, 1'b0, W'(136'h12));
    cyc(1'b1, W'(136'h13), 1'b1);
    chk3("alt13_two", 1'b1, 1'b1, W'(136'h12));
    cyc(1'b1, W'(136'h14), 1'b0);
    chk3("alt13_out", 1'b1, 1'b0, W'(136'h13));
    cyc(1'b1, W'(136'h14), 1'b0);
    chk3("alt14", 1'b1, 1'b0, W'(136'h14));
    cyc(1'b0, '0, 1'b0);
    chkb("alt_empty_vld", sig_buf_vld, 1'b0);

    // Reset while full must discard both entries.
    cyc(1'b1, W'(136'haa), 1'b1);
    cyc(1'b1, W'(136'hbb), 1'b1);
    chk3("pre_rst_two", 1'b1, 1'b1, W'(136'haa));
    rst = 1'b1;
    cyc(1'b1, W'(136'hcc), 1'b1);
    chk3("rst_two", 1'b0, 1'b0, '0);
    rst = 1'b0;
    cyc(1'b0, '0, 1'b0);
    chk3("after_rst1", 1'b0, 1'b0, '0);
    cyc(1'b0, '0, 1'b0);
    chk3("after_rst2", 1'b0, 1'b0, '0);

    // Random traffic against a queue model.
    cnt  = 0;
    hold = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      chkb("rnd_vld", sig_buf_vld, q.size() != 0);
      chkb("rnd_stall", stall_out, q.size() == 2);
      if (q.size() != 0) chk("rnd_data", sig_buf, q[0]);
      if (!hold) begin
        sig_vld = 1'($urandom_range(0, 1));
        if (sig_vld) begin
          cnt++;
          sig = {8'(cnt), $urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
      stall_in = 1'($urandom_range(0, 1));
      acc = sig_vld && (q.size() != 2);
      con = (q.size() != 0) && !stall_in;
      if (con) void'(q.pop_front());
      if (acc) q.push_back(sig);
      hold = sig_vld && !acc;
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
